// File: rtl/mmc_pkg.sv
// Shared types for the MMC command sequencer: counter modes,
// sequencer states and the queued command record.
package mmc_pkg;

    typedef enum logic [1:0] {
        UP_1 = 2'b00,
        UP_2 = 2'b01,
        DW_1 = 2'b10,
        DW_2 = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE
    } state_e;

    typedef struct packed {
        ctrl_e      op;
        logic       load;
        logic [2:0] val;
        logic [3:0] rpt;
    } cmd_t;

endpackage

// File: rtl/mmc_cmd_fifo.sv
// Command FIFO for the sequencer: power-of-two depth,
// head visible on dout, synchronous clear.
module mmc_cmd_fifo
    import mmc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  cmd_t                   din,
    output cmd_t                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmc_cmd_seq.sv
// Command sequencer driving the game counter: queues mode/preload
// commands and plays each for rpt+1 cycles, pausing on gameover.
module mmc_cmd_seq
    import mmc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAUSE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic                   cmd_load,
    input  logic [2:0]             cmd_val,
    input  logic [3:0]             cmd_rpt,
    input  logic                   flush,
    input  logic [2:0]             count_in,
    input  logic                   gameover,
    output logic [1:0]             ctrl,
    output logic                   init,
    output logic [2:0]             init_val,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             done_cnt
);

    localparam int PW = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_CYC - 1);

    state_e        state, state_d;
    cmd_t          cur, cur_d;
    cmd_t          head, push_cmd;
    logic [3:0]    rpt_cnt, rpt_d;
    logic [PW-1:0] pause_cnt, pause_d;
    logic [7:0]    done_d;
    logic          rdy_en;
    logic          full, empty;
    logic          push, pop;

    assign push_cmd = '{op: ctrl_e'(cmd_op), load: cmd_load,
                        val: cmd_val, rpt: cmd_rpt};
    assign cmd_ready = rdy_en && !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

    mmc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (flush),
        .din   (push_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur       <= '0;
            rpt_cnt   <= '0;
            pause_cnt <= '0;
            done_cnt  <= '0;
            rdy_en    <= 1'b0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            rpt_cnt   <= rpt_d;
            pause_cnt <= pause_d;
            done_cnt  <= done_d;
            rdy_en    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        cur_d   = cur;
        rpt_d   = rpt_cnt;
        pause_d = pause_cnt;
        done_d  = done_cnt;
        pop     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            rpt_d   = '0;
            pause_d = '0;
        end else if (gameover) begin
            state_d = PAUSE;
            rpt_d   = '0;
            pause_d = PAUSE_LAST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        cur_d   = head;
                        rpt_d   = head.rpt;
                        state_d = head.load ? LOAD : RUN;
                    end
                end
                LOAD: state_d = RUN;
                RUN: begin
                    if (rpt_cnt == 4'd0) begin
                        if (done_cnt != 8'hff)
                            done_d = done_cnt + 8'd1;
                        // Chain straight into the next command, no gap.
                        if (!empty) begin
                            pop     = 1'b1;
                            cur_d   = head;
                            rpt_d   = head.rpt;
                            state_d = head.load ? LOAD : RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rpt_d = rpt_cnt - 4'd1;
                    end
                end
                PAUSE: begin
                    if (pause_cnt == '0)
                        state_d = IDLE;
                    else
                        pause_d = pause_cnt - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Idle and pause hold the counter by reloading its own value.
    always_comb begin
        ctrl     = UP_1;
        init     = 1'b1;
        init_val = count_in;
        unique case (state)
            LOAD: begin
                ctrl     = cur.op;
                init_val = cur.val;
            end
            RUN: begin
                ctrl     = cur.op;
                init     = 1'b0;
                init_val = cur.val;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmc_cmd_seq.sv
// Directed vector bench for mmc_cmd_seq: a per-cycle table plus
// hand sequences for pause, flush and mid-command reset.
module tb_mmc_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic [2:0] cmd_val;
    logic [3:0] cmd_rpt;
    logic       flush;
    logic [2:0] count_in;
    logic       gameover;
    logic [1:0] ctrl;
    logic       init;
    logic [2:0] init_val;
    logic       busy;
    logic [2:0] level;
    logic [7:0] done_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic       ld;
        logic [2:0] val;
        logic [3:0] rpt;
        logic       fl;
        logic       go;
        logic [2:0] cin;
        logic [1:0] e_ctrl;
        logic       e_init;
        logic [2:0] e_iv;
        logic       e_ivchk;
        logic       e_busy;
        logic [2:0] e_lvl;
        logic       e_rdy;
        logic [7:0] e_done;
    } vec_t;

    vec_t tbl[$];

    mmc_cmd_seq #(.DEPTH(4), .PAUSE_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_val   (cmd_val),
        .cmd_rpt   (cmd_rpt),
        .flush     (flush),
        .count_in  (count_in),
        .gameover  (gameover),
        .ctrl      (ctrl),
        .init      (init),
        .init_val  (init_val),
        .busy      (busy),
        .level     (level),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic v, input logic [1:0] op, input logic ld,
        input logic [2:0] val, input logic [3:0] rpt,
        input logic fl, input logic go, input logic [2:0] cin,
        input logic [1:0] ectrl, input logic einit,
        input logic [2:0] eiv, input logic eivchk,
        input logic ebusy, input logic [2:0] elvl,
        input logic erdy, input logic [7:0] edone);
        vec_t x;
        x.v = v; x.op = op; x.ld = ld; x.val = val; x.rpt = rpt;
        x.fl = fl; x.go = go; x.cin = cin;
        x.e_ctrl = ectrl; x.e_init = einit;
        x.e_iv = eiv; x.e_ivchk = eivchk;
        x.e_busy = ebusy; x.e_lvl = elvl;
        x.e_rdy = erdy; x.e_done = edone;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input vec_t x);
        check({tag, ".ctrl"}, int'(ctrl), int'(x.e_ctrl));
        check({tag, ".init"}, int'(init), int'(x.e_init));
        if (x.e_ivchk)
            check({tag, ".init_val"}, int'(init_val), int'(x.e_iv));
        check({tag, ".busy"}, int'(busy), int'(x.e_busy));
        check({tag, ".level"}, int'(level), int'(x.e_lvl));
        check({tag, ".cmd_ready"}, int'(cmd_ready), int'(x.e_rdy));
        check({tag, ".done_cnt"}, int'(done_cnt), int'(x.e_done));
    endtask

    // Called just after a falling edge; checks before the next rise.
    task automatic apply(input string tag, input vec_t x);
        cmd_valid = x.v;
        cmd_op    = x.op;
        cmd_load  = x.ld;
        cmd_val   = x.val;
        cmd_rpt   = x.rpt;
        flush     = x.fl;
        gameover  = x.go;
        count_in  = x.cin;
        #1;
        expect_out(tag, x);
        @(negedge clk);
    endtask

    initial begin
        // single command with preload, then queue fill and drain
        tbl.push_back(mk(1,0,1,3,2,0,0,5, 0,1,5,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,1,3,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,0,0,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,0,0,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,0,0,0,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,1,1));
        tbl.push_back(mk(1,1,0,0,3,0,0,5, 0,1,5,1,0,0,1,1));
        tbl.push_back(mk(1,2,0,0,0,0,0,5, 0,1,5,1,0,1,1,1));
        tbl.push_back(mk(1,3,0,0,0,0,0,5, 1,0,0,0,1,1,1,1));
        tbl.push_back(mk(1,0,1,6,0,0,0,5, 1,0,0,0,1,2,1,1));
        tbl.push_back(mk(1,1,0,0,1,0,0,5, 1,0,0,0,1,3,1,1));
        tbl.push_back(mk(1,2,0,0,0,0,0,5, 1,0,0,0,1,4,0,1));
        tbl.push_back(mk(1,2,0,0,0,0,0,5, 2,0,0,0,1,3,1,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 3,0,0,0,1,3,1,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,1,6,1,1,2,1,4));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 0,0,0,0,1,2,1,4));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 1,0,0,0,1,1,1,5));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 1,0,0,0,1,1,1,5));
        tbl.push_back(mk(0,0,0,0,0,0,0,5, 2,0,0,0,1,0,1,6));
        tbl.push_back(mk(0,0,0,0,0,0,0,2, 0,1,2,1,0,0,1,7));

        rst = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_load = 0; cmd_val = 0;
        cmd_rpt = 0; flush = 0; gameover = 0; count_in = 5;
        #2;
        expect_out("reset", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,0,0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // gameover mid-run of a 16-cycle command, one command queued
        apply("go_a", mk(1,3,0,0,15,0,0,5, 0,1,5,1,0,0,1,7));
        apply("go_b", mk(1,2,1,4,0,0,0,5, 0,1,5,1,0,1,1,7));
        apply("go_c", mk(0,0,0,0,0,0,0,5, 3,0,0,0,1,1,1,7));
        apply("go_d", mk(0,0,0,0,0,0,1,5, 3,0,0,0,1,1,1,7));
        for (int i = 0; i < 4; i++)
            apply($sformatf("go_p%0d", i),
                  mk(0,0,0,0,0,0,0,6, 0,1,6,1,1,1,1,7));
        apply("go_i", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,1,1,7));
        apply("go_j", mk(0,0,0,0,0,0,0,5, 2,1,4,1,1,0,1,7));
        apply("go_k", mk(0,0,0,0,0,0,0,5, 2,0,0,0,1,0,1,7));
        apply("go_l", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,1,8));

        // gameover during pause restarts the hold count
        apply("pr_a", mk(0,0,0,0,0,0,1,5, 0,1,5,1,0,0,1,8));
        apply("pr_b", mk(0,0,0,0,0,0,0,5, 0,1,5,1,1,0,1,8));
        apply("pr_c", mk(0,0,0,0,0,0,1,5, 0,1,5,1,1,0,1,8));
        for (int i = 0; i < 4; i++)
            apply($sformatf("pr_p%0d", i),
                  mk(0,0,0,0,0,0,0,5, 0,1,5,1,1,0,1,8));
        apply("pr_h", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,1,8));

        // flush (with gameover) at level 3 mid-run
        apply("fl_a", mk(1,1,0,0,15,0,0,5, 0,1,5,1,0,0,1,8));
        apply("fl_b", mk(1,2,0,0,0,0,0,5, 0,1,5,1,0,1,1,8));
        apply("fl_c", mk(1,3,0,0,0,0,0,5, 1,0,0,0,1,1,1,8));
        apply("fl_d", mk(1,0,0,0,0,0,0,5, 1,0,0,0,1,2,1,8));
        apply("fl_e", mk(1,1,0,0,0,1,1,5, 1,0,0,0,1,3,0,8));
        apply("fl_f", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,1,8));
        apply("fl_g", mk(0,0,0,0,0,0,0,5, 0,1,5,1,0,0,1,8));

        // asynchronous reset asserted in the middle of LOAD
        apply("rs_a", mk(1,2,1,7,3,0,0,5, 0,1,5,1,0,0,1,8));
        apply("rs_b", mk(1,3,0,0,0,0,0,5, 0,1,5,1,0,1,1,8));
        cmd_valid = 0;
        count_in  = 3;
        #1;
        expect_out("rs_load", mk(0,0,0,0,0,0,0,3, 2,1,7,1,1,1,1,8));
        #1;
        rst = 1'b0;
        #1;
        expect_out("rs_mid", mk(0,0,0,0,0,0,0,3, 0,1,3,1,0,0,0,0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply("rs_rel", mk(0,0,0,0,0,0,0,3, 0,1,3,1,0,0,1,0));
        apply("rs_idle", mk(0,0,0,0,0,0,0,3, 0,1,3,1,0,0,1,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
